// File: rtl/fetch_pkg_r32i.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg_r32i;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fifo_sync_r32i.sv
// Synchronous FIFO with flush; head is read from registered storage, visible the cycle after push.
// Push and pop may share a cycle, flush wins over both; the caller guarantees no push into a full FIFO.
module fifo_sync_r32i #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_r32i.sv
// RV32I fetch stage: owns the PC, fetches over req/gnt/rvalid, buffers {addr,data} for the decoder (1-cycle mem -> InsValid 2 cycles after req).
// Credit-limited to DEPTH words in flight plus buffered; FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into FetchFault.
module fetch_unit_r32i
    import fetch_pkg_r32i::*;
#(
    parameter int          dataW    = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ImemReq,
    output logic [dataW-1:0] ImemAddr,
    input  logic             ImemGnt,
    input  logic             ImemRValid,
    input  logic [dataW-1:0] ImemRData,
    output logic             InsValid,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] InsAddr,
    input  logic             InsReady,
    input  logic             Redirect,
    input  logic [dataW-1:0] RedirectAddr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             FetchFault
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [dataW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [CW-1:0]    buf_count, pend_count;
    logic [CW:0]      slots_used;
    logic [dataW-1:0] pend_head;
    fetch_entry_t     buf_head, buf_wdata;
    logic             grant, resp_drop, resp_keep, ins_pop;
    logic             pc_load, fetch_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             fault_q, fault_d;
    logic [dataW-1:0] fault_addr_q, fault_addr_d;
    logic             misaligned;

    assign misaligned   = (RedirectAddr[1:0] != 2'b00);
    assign pc_load      = Redirect && !misaligned;
    assign fetch_block  = fault_q;
    assign fault_d      = Redirect ? misaligned : fault_q;
    assign fault_addr_d = (Redirect && misaligned) ? RedirectAddr : fault_addr_q;
    assign FetchFault   = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^RedirectAddr[1:0];
    assign pc_load         = Redirect;
    assign fetch_block     = 1'b0;
`endif

    assign ins_pop = InsValid && InsReady;

    // A word leaving the buffer this cycle frees its slot immediately, which sustains one fetch per cycle.
    assign slots_used = {1'b0, outstanding_q} + {1'b0, buf_count} - {{CW{1'b0}}, ins_pop};
    assign ImemReq    = !rst && !Redirect && !fetch_block && (slots_used < (CW+1)'(DEPTH));
    assign ImemAddr   = fetch_pc_q;
    assign grant      = ImemReq && ImemGnt;

    assign resp_drop = ImemRValid && ((drop_q != '0) || Redirect);
    assign resp_keep = ImemRValid && !resp_drop;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(ImemRValid);
        drop_d        = drop_q;
        if (pc_load) begin
            fetch_pc_d = {RedirectAddr[dataW-1:2], 2'b00};
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + dataW'(INSTR_BYTES);
        end
        if (Redirect) begin
            drop_d = outstanding_q - CW'(ImemRValid);
        end else if (resp_drop) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fifo_sync_r32i #(
        .WIDTH (dataW),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (Redirect),
        .push_i  (grant),
        .wdata_i (fetch_pc_q),
        .pop_i   (resp_keep),
        .rdata_o (pend_head),
        .count_o (pend_count)
    );

    assign buf_wdata = '{addr: pend_head, data: ImemRData};

    fifo_sync_r32i #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (Redirect),
        .push_i  (resp_keep),
        .wdata_i (buf_wdata),
        .pop_i   (ins_pop),
        .rdata_o (buf_head),
        .count_o (buf_count)
    );

    assign InsValid = !rst && (buf_count != '0);
    assign rawIns   = InsValid ? buf_head.data : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign InsAddr  = fault_q ? fault_addr_q : (InsValid ? buf_head.addr : '0);
`else
    assign InsAddr  = InsValid ? buf_head.addr : '0;
`endif

    // Every live (non-dropped) fetch has exactly one pending address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ImemRValid && (outstanding_q == '0)));
            assert (pend_count == (outstanding_q - drop_q));
        end
    end

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// Randomized scoreboard bench for fetch_unit_r32i: memory model plus expected in-order instruction stream.
module tb_fetch_unit_r32i;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ImemReq, ImemGnt, ImemRValid;
    logic [31:0] ImemAddr, ImemRData;
    logic        InsValid, InsReady, Redirect;
    logic [31:0] rawIns, InsAddr, RedirectAddr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        FetchFault;
`endif

    fetch_unit_r32i #(
        .dataW    (32),
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemGnt      (ImemGnt),
        .ImemRValid   (ImemRValid),
        .ImemRData    (ImemRData),
        .InsValid     (InsValid),
        .rawIns       (rawIns),
        .InsAddr      (InsAddr),
        .InsReady     (InsReady),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .FetchFault   (FetchFault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] glog[$];
    logic [31:0] exp_pc;
    logic        fault_exp;
    int          cyc = 0, grants = 0, deliv = 0;
    int          gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    int          n_checks = 0, n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // One clock cycle of stimulus: drive inputs at negedge, then update the reference model.
    task automatic step(input logic redir, input logic [31:0] target);
        @(negedge clk);
        cyc++;
        rst          = 1'b0;
        Redirect     = redir;
        RedirectAddr = target;
        ImemGnt      = ($urandom_range(99) < gnt_pct);
        InsReady     = ($urandom_range(99) < rdy_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ImemRValid = 1'b1;
            ImemRData  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            ImemRValid = 1'b0;
            ImemRData  = $urandom;
        end
        #1;
        if (redir) begin
            check_b("req_low_on_redirect", ImemReq, 1'b0);
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_exp = (target[1:0] != 2'b00);
`endif
            exp_pc = {target[31:2], 2'b00};
        end else if (fault_exp) begin
            check_b("req_low_in_fault", ImemReq, 1'b0);
        end
        if (ImemReq && ImemGnt) begin
            check("fetch_addr", ImemAddr, exp_pc);
            mem_q.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)), addr: ImemAddr});
            exp_q.push_back('{addr: exp_pc, data: mem_word(exp_pc)});
            glog.push_back(ImemAddr);
            exp_pc = exp_pc + 32'd4;
            grants++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        Redirect   = 1'b0;
        ImemGnt    = 1'($urandom_range(1));
        ImemRValid = 1'b0;
        InsReady   = 1'($urandom_range(1));
        #1;
        check_b("rst_req", ImemReq, 1'b0);
        check_b("rst_valid", InsValid, 1'b0);
        check("rst_raw", rawIns, 32'h0);
        check("rst_addr", InsAddr, 32'h0);
        @(negedge clk);
        #1;
        mem_q.delete();
        exp_q.delete();
        exp_pc    = RST_PC;
        fault_exp = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_b("rst_fault", FetchFault, 1'b0);
`endif
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_addr);
        int n = 1;
        step(1'b0, 32'h0);
        while (!InsValid && n < 30) begin
            step(1'b0, 32'h0);
            n++;
        end
        if (!InsValid) begin
            n_checks++;
            $display("FAIL %s: no InsValid within 30 cycles, expected addr %h", name, exp_addr);
        end else begin
            check(name, InsAddr, exp_addr);
        end
    endtask

    // Scoreboard monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        #2;
        if (!rst && !Redirect && InsValid && InsReady) begin
            deliv++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ins_unexpected: got addr %h data %h, expected nothing", InsAddr, rawIns);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ins_addr", InsAddr, e.addr);
                check("ins_data", rawIns, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp [3];
        logic [31:0] t;
        int g0, d0;
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        rst = 1'b1; Redirect = 1'b0; RedirectAddr = '0; ImemGnt = 1'b0;
        ImemRValid = 1'b0; ImemRData = '0; InsReady = 1'b0;
        fault_exp = 1'b0; exp_pc = RST_PC;

        // Reset release latency and back-to-back delivery.
        do_reset();
        step(1'b0, 32'h0);
        check_b("c0_req", ImemReq, 1'b1);
        check("c0_addr", ImemAddr, RST_PC);
        check_b("c0_valid", InsValid, 1'b0);
        step(1'b0, 32'h0);
        check_b("c1_rvalid", ImemRValid, 1'b1);
        check_b("c1_valid", InsValid, 1'b0);
        step(1'b0, 32'h0);
        check_b("c2_valid", InsValid, 1'b1);
        check("c2_addr", InsAddr, RST_PC);
        step(1'b0, 32'h0);
        check_b("c3_valid", InsValid, 1'b1);
        check("c3_addr", InsAddr, RST_PC + 32'd4);
        step(1'b0, 32'h0);
        check_b("c4_valid", InsValid, 1'b1);
        check("c4_addr", InsAddr, RST_PC + 32'd8);

        // Decoder stall: credit limits fetches to DEPTH.
        do_reset();
        rdy_pct = 0;
        g0 = grants;
        repeat (5) step(1'b0, 32'h0);
        check("stall_grants", grants - g0, 32'd2);
        check_b("stall_req_low", ImemReq, 1'b0);
        d0 = deliv;
        rdy_pct = 100;
        repeat (4) step(1'b0, 32'h0);
        check_b("stall_drain", (deliv - d0) >= 2, 1'b1);

        // Redirect with two slow fetches outstanding.
        do_reset();
        lat_min = 3; lat_max = 3;
        g0 = grants;
        repeat (2) step(1'b0, 32'h0);
        check("slow_grants", grants - g0, 32'd2);
        step(1'b1, 32'h100);
        wait_valid("slow_redirect_target", 32'h100);

        // Redirect coincident with a response and a decoder handshake.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        check_b("coinc_rvalid", ImemRValid, 1'b1);
        check_b("coinc_valid", InsValid, 1'b1);
        step(1'b0, 32'h0);
        check_b("post_redirect_valid", InsValid, 1'b0);
        wait_valid("coinc_target", 32'h200);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFF8);
        glog.delete();
        repeat (6) step(1'b0, 32'h0);
        if (glog.size() < 3) begin
            n_checks++;
            $display("FAIL wrap_grants: got %0d grants, expected at least 3", glog.size());
        end else begin
            for (int i = 0; i < 3; i++) check("wrap_addr", glog[i], wrap_exp[i]);
        end

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
        step(1'b1, 32'h102);
        step(1'b0, 32'h0);
        check_b("fault_set", FetchFault, 1'b1);
        check("fault_addr", InsAddr, 32'h102);
        check_b("fault_req", ImemReq, 1'b0);
        repeat (4) step(1'b0, 32'h0);
        check_b("fault_hold", FetchFault, 1'b1);
        step(1'b1, 32'h200);
        step(1'b0, 32'h0);
        check_b("fault_clear", FetchFault, 1'b0);
        wait_valid("fault_resume", 32'h200);
`else
        step(1'b1, 32'h102);
        wait_valid("misalign_resume", 32'h100);
`endif

        // Randomized traffic with redirects and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                gnt_pct = int'($urandom_range(100, 30));
                rdy_pct = int'($urandom_range(100, 20));
                lat_min = 1;
                lat_max = int'($urandom_range(4, 1));
            end
            if ($urandom_range(999) < 3) begin
                do_reset();
            end else if ($urandom_range(99) < 3) begin
                t = $urandom;
                if ($urandom_range(3) != 0) t[1:0] = 2'b00;
                step(1'b1, t);
            end else begin
                step(1'b0, 32'h0);
            end
        end

        // Drain: stop granting, everything fetched must be delivered.
        gnt_pct = 0;
        rdy_pct = 100;
        repeat (30) step(1'b0, 32'h0);
        check("drain_empty", exp_q.size(), 32'd0);
        check_b("drain_valid", InsValid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit_r32i.md
Name: fetch_unit_r32i

Overview:
- Instruction fetch stage directly upstream of the RV32I decoder.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned words with their addresses and presents them to the decoder with a valid/ready handshake.
- Accepts PC redirects from the branch resolution logic and flushes stale work.

Parameters:
- dataW, 32, data/address width; only 32 is supported.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, maximum fetches in flight plus buffered (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  dataW  word-aligned fetch address (equal to fetchPC).
- ImemGnt  in  1  request accepted this cycle.
- ImemRValid  in  1  response valid. Responses are in order, at least 1 cycle after grant.
- ImemRData  in  dataW  returned instruction word.
- InsValid  out  1  rawIns/InsAddr are valid.
- rawIns  out  dataW  instruction to the decoder.
- InsAddr  out  dataW  address of rawIns.
- InsReady  in  1  decoder accepts the instruction this cycle.
- Redirect  in  1  load a new PC (taken branch or jump).
- RedirectAddr  in  dataW  redirect target.

Behaviour:
- Reset: fetchPC=RESET_PC, buffer empty, outstanding=0, drop=0. Outputs: InsValid=0, rawIns=0, InsAddr=0, ImemReq=0 during the rst cycle.
- ImemReq = !rst & !Redirect & (outstanding + bufCount < DEPTH). The block is combinational from Redirect.
- Grant (ImemReq & ImemGnt):
  - push fetchPC into the pending-address queue;
  - fetchPC += 4, wrapping modulo 2^32 (32'hFFFF_FFFC wraps to 0);
  - outstanding++.
- Response (ImemRValid), with drop==0: pop the pending-address queue and write {addr, data} into the buffer; outstanding--.
- Response with drop>0: discard the response; drop--, outstanding--.
- Output: buffer head is registered. InsValid = bufCount>0. The head pops on InsValid & InsReady.
- Latency: with a 1-cycle memory, response data appears as InsValid in the cycle after ImemRValid. After rst falls: cycle 0 request for RESET_PC, cycle 1 rvalid, cycle 2 InsValid.
- Throughput: one instruction per cycle sustained with 1-cycle memory and InsReady held high.
- Full: the credit check prevents buffer overflow. A response can never arrive with the buffer full.
- Empty: InsValid=0. InsReady is ignored.
- Redirect cycle:
  - fetchPC <= RedirectAddr with bits [1:0] forced to 0;
  - buffer and pending-address queue flushed;
  - drop <= outstanding minus any response discarded this cycle;
  - InsValid=0 from the next cycle. A simultaneous InsReady handshake is void.
- Redirect plus ImemRValid in the same cycle: that response is discarded.
- Redirect while drop>0: drop accumulates correctly and never underflows.
- Reset mid-operation: instruction memory shares rst. All counters clear. An ImemRValid with outstanding==0 is illegal; an assertion fires on it.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - extra output FetchFault (1 bit), reset 0;
  - a redirect with RedirectAddr[1:0]!=0 sets FetchFault, stores the raw address in InsAddr, and suppresses ImemReq;
  - state holds until the next redirect with an aligned target, which clears FetchFault.
- Undefined: low bits are silently cleared; no FetchFault port.

Decomposition:
- Shared package fetch_pkg_r32i:
  - constant INSTR_BYTES=4;
  - RESET_PC default;
  - typedef fetch_entry_t {addr, data}.
- One sub-module: fifo_sync_r32i (parameterised width/depth, sync reset, flush input). Instantiated twice: pending-address queue and output buffer.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory, InsReady=1 -> ImemAddr sequence 0,4,8,...; InsValid in cycle 2; InsAddr 0,4,8 back-to-back.
- InsReady=0 for 5 cycles -> at most DEPTH=2 grants, then ImemReq=0. On release, instructions at 0 and 4 delivered in order, none lost.
- 3-cycle memory latency, Redirect to 32'h100 with 2 outstanding -> both late responses discarded; next InsAddr=32'h100.
- Redirect coincident with ImemRValid and InsReady -> response dropped, handshake void; next InsValid carries the target address.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 32'h102:
  - with FETCH_MISALIGN_TRAP_EN: FetchFault=1, ImemReq=0 until a redirect to 32'h200;
  - without: fetch resumes at 32'h100.
